// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider FSM states and the divide-by-zero quotient.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [ALU_WIDTH-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial remainder and
// subtract the divisor when it fits.
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] t;

  // The partial remainder is always below the divisor, so T - divisor fits in WIDTH bits
  // whenever the (WIDTH+1)-bit compare succeeds.
  always_comb begin
    t      = {r[WIDTH-2:0], q_msb};
    q_bit  = ({r[WIDTH-1], t} >= {1'b0, divisor});
    r_next = q_bit ? (t - divisor) : t;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, done pulse with quotient/remainder.
// Define DIV_SIGNED_EN for two's-complement operands (truncating quotient, remainder takes dividend sign).
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             zpend_q, zpend_d;

  logic [WIDTH-1:0] step_r;
  logic             step_qbit;
  logic [WIDTH-1:0] q_shift;

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .q_msb   (q_q[WIDTH-1]),
    .divisor (dvsr_q),
    .r_next  (step_r),
    .q_bit   (step_qbit)
  );

  assign q_shift = {q_q[WIDTH-2:0], step_qbit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    zpend_d = zpend_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          r_d     = '0;
          dvsr_d  = divisor;
          cnt_d   = CNT_W'(WIDTH - 1);
          zpend_d = (divisor == '0);
          q_d     = dividend;
`ifdef DIV_SIGNED_EN
          if (divisor != '0) begin
            q_d    = magnitude(dividend);
            dvsr_d = magnitude(divisor);
          end
          qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d = dividend[WIDTH-1];
`endif
        end
      end
      CALC: begin
        // A zero divisor spends one cycle here (holding the raw dividend in Q) so its
        // done lands two cycles after start.
        if (zpend_q) begin
          state_d = DONE;
          zpend_d = 1'b0;
          quot_d  = {WIDTH{DIV0_QUOT[0]}};
          rem_d   = q_q;
          dbz_d   = 1'b1;
        end else begin
          r_d = step_r;
          q_d = q_shift;
          if (cnt_q == '0) begin
            state_d = DONE;
            dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
            quot_d  = apply_sign(q_shift, qneg_q);
            rem_d   = apply_sign(step_r, rneg_q);
`else
            quot_d  = q_shift;
            rem_d   = step_r;
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      zpend_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      zpend_q <= zpend_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
